// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the raster timing generator: the default
// 640x480@60 set, an 800x600@60 set and the sync polarity encodings.
package vga_timing_pkg;

    // Sync polarity: the level driven on o_hs/o_vs while in the sync region.
    localparam bit SYNC_POL_NEG = 1'b0;
    localparam bit SYNC_POL_POS = 1'b1;

    // One axis of a video mode: active region followed by the three blanking regions.
    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
        bit          pol;
    } axis_timing_t;

    // 640x480@60 (25.175 MHz pixel clock), negative syncs.
    localparam axis_timing_t VGA640_H = '{active: 640, fp: 16, sync: 96, bp: 48, pol: SYNC_POL_NEG};
    localparam axis_timing_t VGA640_V = '{active: 480, fp: 10, sync: 2,  bp: 33, pol: SYNC_POL_NEG};

    // 800x600@60 (40 MHz pixel clock), positive syncs.
    localparam axis_timing_t SVGA800_H = '{active: 800, fp: 40, sync: 128, bp: 88, pol: SYNC_POL_POS};
    localparam axis_timing_t SVGA800_V = '{active: 600, fp: 1,  sync: 4,   bp: 23, pol: SYNC_POL_POS};

    // Total number of slots on one axis.
    function automatic int unsigned axis_total(input axis_timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus the combinational
// decodes of its active region, sync level and clamped coordinate.
// Instantiated once for the horizontal axis and once for the vertical axis.
module vga_axis_counter #(
    parameter int unsigned ACTIVE = 640,
    parameter int unsigned FP     = 16,
    parameter int unsigned SYNC   = 96,
    parameter int unsigned BP     = 48,
    parameter bit          POL    = 1'b0,
    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int unsigned W     = $clog2(TOTAL)
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_adv,
    output logic [W-1:0] o_count,
    output logic         o_wrap,
    output logic         o_active,
    output logic         o_sync,
    output logic [W-1:0] o_coord
);

    if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_param_err
        $error("vga_axis_counter: every timing region must be at least one slot long");
    end

    localparam logic [W-1:0] C_LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] C_ACT_LAST   = W'(ACTIVE - 1);
    localparam logic [W-1:0] C_SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] C_SYNC_END   = W'(ACTIVE + FP + SYNC - 1);

    logic [W-1:0] r_count;
    logic         w_last;

    assign w_last = (r_count == C_LAST);

    // Position counter: advances on i_adv and wraps from the last slot to 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_adv) begin
            r_count <= w_last ? '0 : (r_count + W'(1));
        end
    end

    assign o_count  = r_count;
    assign o_wrap   = i_adv & w_last;
    assign o_active = (r_count <= C_ACT_LAST);
    assign o_sync   = ((r_count >= C_SYNC_START) && (r_count <= C_SYNC_END)) ? POL : ~POL;
    assign o_coord  = o_active ? r_count : C_ACT_LAST;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: H/V sync, active/blanking, clamped
// pixel coordinates and one-clock line/frame/animate/scan-line-irq events.
// All level outputs decode the count registers directly (zero latency);
// event pulses are qualified by the advance so they are one clock wide at
// any pixel-strobe rate. Optional feature macro: VGA_TIMING_FRAME_CNT_EN
// adds a 16-bit wrapping frame counter on o_frame_cnt.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA640_H.active,
    parameter int unsigned H_FP       = VGA640_H.fp,
    parameter int unsigned H_SYNC     = VGA640_H.sync,
    parameter int unsigned H_BP       = VGA640_H.bp,
    parameter int unsigned V_ACTIVE   = VGA640_V.active,
    parameter int unsigned V_FP       = VGA640_V.fp,
    parameter int unsigned V_SYNC     = VGA640_V.sync,
    parameter int unsigned V_BP       = VGA640_V.bp,
    parameter bit          H_SYNC_POL = VGA640_H.pol,
    parameter bit          V_SYNC_POL = VGA640_V.pol,
    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW        = $clog2(H_TOTAL),
    localparam int unsigned VW        = $clog2(V_TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_pix_stb,
    input  logic          i_en,
    input  logic [VW-1:0] i_irq_line,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_active,
    output logic          o_blanking,
    output logic [HW-1:0] o_x,
    output logic [VW-1:0] o_y,
    output logic          o_line_end,
    output logic          o_frame_end,
    output logic          o_animate,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [15:0]   o_frame_cnt,
`endif
    output logic          o_irq
);

    logic          w_adv;
    logic [HW-1:0] w_h_count;
    logic [VW-1:0] w_v_count;
    logic          w_h_wrap;
    logic          w_v_wrap;
    logic          w_h_active;
    logic          w_v_active;

    assign w_adv = i_pix_stb & i_en;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (H_SYNC_POL)
    ) u_h_axis (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_adv    (w_adv),
        .o_count  (w_h_count),
        .o_wrap   (w_h_wrap),
        .o_active (w_h_active),
        .o_sync   (o_hs),
        .o_coord  (o_x)
    );

    // The vertical axis steps once per horizontal wrap.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (V_SYNC_POL)
    ) u_v_axis (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_adv    (w_h_wrap),
        .o_count  (w_v_count),
        .o_wrap   (w_v_wrap),
        .o_active (w_v_active),
        .o_sync   (o_vs),
        .o_coord  (o_y)
    );

    assign o_active    = w_h_active & w_v_active;
    assign o_blanking  = ~o_active;
    assign o_line_end  = w_h_wrap;
    assign o_frame_end = w_v_wrap;
    assign o_animate   = w_h_wrap & (w_v_count == VW'(V_ACTIVE - 1));
    // i_irq_line values at or beyond V_TOTAL can never match the vertical count.
    assign o_irq       = w_adv & (w_h_count == HW'(H_ACTIVE)) & (w_v_count == i_irq_line);

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Frame counter: one step per completed frame, wraps naturally at 16 bits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_v_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small custom mode so several frames fit in a
// short run. The stimulus process tracks the raster as one linear pixel index
// and pushes the expected outputs for each cycle; the monitor pops and checks.
module tb_vga_timing_gen;

    localparam int HA = 10, HF = 2, HS = 3, HB = 4;
    localparam int VA = 6,  VF = 1, VS = 2, VB = 3;
    localparam bit HPOL = 1'b0, VPOL = 1'b1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int HW = $clog2(HT);
    localparam int VW = $clog2(VT);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pix_stb = 1'b0;
    logic          en = 1'b0;
    logic [VW-1:0] irq_line = '0;
    logic          hs, vs, active, blanking, line_end, frame_end, animate, irq;
    logic [HW-1:0] x;
    logic [VW-1:0] y;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_SYNC_POL(HPOL), .V_SYNC_POL(VPOL)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pix_stb   (pix_stb),
        .i_en        (en),
        .i_irq_line  (irq_line),
        .o_hs        (hs),
        .o_vs        (vs),
        .o_active    (active),
        .o_blanking  (blanking),
        .o_x         (x),
        .o_y         (y),
        .o_line_end  (line_end),
        .o_frame_end (frame_end),
        .o_animate   (animate),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .o_frame_cnt (frame_cnt),
`endif
        .o_irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit hs, vs, active, blanking, line_end, frame_end, animate, irq;
        int x, y, fcnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   pos    = 0;   // linear pixel index within the frame
    int   fcnt   = 0;   // frames completed since reset

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs straight from the region rules for a raster position.
    function automatic exp_t model(input int p, input bit adv, input int line, input int frames);
        exp_t e;
        int h, v;
        h = p % HT;
        v = p / HT;
        e.hs        = (h >= HA + HF && h < HA + HF + HS) ? HPOL : !HPOL;
        e.vs        = (v >= VA + VF && v < VA + VF + VS) ? VPOL : !VPOL;
        e.active    = (h < HA) && (v < VA);
        e.blanking  = !e.active;
        e.x         = (h < HA) ? h : HA - 1;
        e.y         = (v < VA) ? v : VA - 1;
        e.line_end  = adv && (h == HT - 1);
        e.frame_end = adv && (p == FRAME - 1);
        e.animate   = adv && (p == VA * HT - 1);
        e.irq       = adv && (h == HA) && (v == line);
        e.fcnt      = frames % 65536;
        return e;
    endfunction

    task automatic drive(input bit stb, input bit enable, input int line, input bit rst);
        @(posedge clk);
        #1;
        rst_n    = !rst;
        pix_stb  = stb;
        en       = enable;
        irq_line = VW'(line);
        if (rst) begin
            pos  = 0;
            fcnt = 0;
        end
        q.push_back(model(pos, stb && enable, line, fcnt));
        if (!rst && stb && enable) begin
            if (pos == FRAME - 1) fcnt++;
            pos = (pos + 1) % FRAME;
        end
    endtask

    // Monitor: every cycle presents a full set of outputs to compare.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("hs",        hs,        e.hs);
            chk("vs",        vs,        e.vs);
            chk("active",    active,    e.active);
            chk("blanking",  blanking,  e.blanking);
            chk("x",         x,         e.x);
            chk("y",         y,         e.y);
            chk("line_end",  line_end,  e.line_end);
            chk("frame_end", frame_end, e.frame_end);
            chk("animate",   animate,   e.animate);
            chk("irq",       irq,       e.irq);
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk("frame_cnt", frame_cnt, e.fcnt);
`endif
        end
    end

    int line_sel;

    initial begin
        // Reset held: outputs must sit at the origin decode.
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, 3, 1'b1);

        // Full-rate strobe, fixed scan line, a little over two frames.
        for (int i = 0; i < 2 * FRAME + 20; i++) drive(1'b1, 1'b1, 3, 1'b0);

        // Strobe every 4th clock, irq on the last line.
        for (int i = 0; i < 4 * FRAME + 8; i++) drive((i % 4) == 3, 1'b1, VT - 1, 1'b0);

        // Out-of-range scan line: irq must stay quiet.
        for (int i = 0; i < 2 * FRAME; i++) drive(1'b1, 1'b1, VT + (i % (16 - VT)), 1'b0);

        // Long freeze at an arbitrary position, then resume.
        for (int i = 0; i < 37; i++) drive(1'b1, 1'b0, 2, 1'b0);
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 2, 1'b0);

        // Random strobe, enable and live-changing scan line with rare resets.
        line_sel = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            if ($urandom_range(0, 15) == 0) line_sel = $urandom_range(0, 15);
            drive($urandom_range(0, 2) != 0, $urandom_range(0, 5) != 0, line_sel,
                  $urandom_range(0, 399) == 0);
        end

        // Mid-frame reset followed by a full frame from the origin.
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 0, 1'b1);
        for (int i = 0; i < FRAME + 5; i++) drive(1'b1, 1'b1, 0, 1'b0);

        @(posedge clk);
        @(posedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator, successor to the fixed 640x480 timing block. Generates H/V sync, active/blanking flags, clamped pixel coordinates and one-tick frame/line events. Adds a run/freeze enable and a programmable scan-line interrupt. Sits between the pixel-strobe divider and the game/renderer logic (snake playfield, sprite drawing).

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, asserted level of o_hs (0 = active-low)
V_SYNC_POL, 0, asserted level of o_vs
Derived localparams: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL).

Ports:
i_clk  in  1  base clock
i_rst_n  in  1  asynchronous active-low reset
i_pix_stb  in  1  pixel strobe; counters advance only on cycles where it is high
i_en  in  1  run enable; low freezes counters and suppresses all event pulses
i_irq_line  in  VW  scan line for o_irq
o_hs  out  1  horizontal sync
o_vs  out  1  vertical sync
o_active  out  1  high while h and v are both in the active region
o_blanking  out  1  exactly ~o_active
o_x  out  HW  h_count, clamped to H_ACTIVE-1 outside the active region
o_y  out  VW  v_count, clamped to V_ACTIVE-1 outside the active region
o_line_end  out  1  one-clk pulse on the last pixel slot of every line
o_frame_end  out  1  one-clk pulse on the last pixel slot of the frame
o_animate  out  1  one-clk pulse on the last pixel slot of the last active line
o_irq  out  1  one-clk pulse at first blanking pixel of line i_irq_line

Behaviour:
- Registered h_count (0..H_TOTAL-1) and v_count (0..V_TOTAL-1). Reset (async, i_rst_n=0) sets both to 0.
- Advance condition adv = i_pix_stb & i_en.
  - On adv with h_count = H_TOTAL-1: h_count wraps to 0 and v_count increments.
  - Otherwise h_count increments.
  - v_count wraps to 0 when it is at V_TOTAL-1 and h wraps.
  - No count ever equals H_TOTAL or V_TOTAL.
- Region order per axis: active [0, ACTIVE-1], front porch, sync, back porch.
  - Sync is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vertical is analogous.
- All level outputs are combinational decodes of the count registers: zero latency relative to the count.
  - Reset values: o_hs = !H_SYNC_POL, o_vs = !V_SYNC_POL, o_active = 1, o_blanking = 0, o_x = 0, o_y = 0, all pulses 0.
- Pulses are decoded from counts ANDed with adv, so each is exactly one clk wide regardless of strobe rate.
  - o_line_end: h = H_TOTAL-1.
  - o_frame_end: h = H_TOTAL-1 and v = V_TOTAL-1; o_line_end fires in the same cycle.
  - o_animate: h = H_TOTAL-1 and v = V_ACTIVE-1.
  - o_irq: h = H_ACTIVE and v = i_irq_line. A value of i_irq_line >= V_TOTAL never fires. i_irq_line is sampled live and may change at any time.
- i_en low: counts hold, level outputs hold, pulses are 0. Resuming continues from the held position.
- Reset mid-frame: counts go to 0 immediately. The next frame after release is full length.
- Elaboration error if any timing parameter is 0.

Optional Feature:
VGA_TIMING_FRAME_CNT_EN
- Defined: adds port o_frame_cnt (out, 16). It resets to 0, increments on each o_frame_end and wraps from 65535 to 0.
- Undefined: the port and its register are absent. All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - the default 640x480 timing constants;
  - an 800x600@60 constant set;
  - the polarity encodings.
- Sub-module vga_axis_counter (params ACTIVE, FP, SYNC, BP, POL) is instantiated twice, for h and v. It provides count, wrap-on-advance, active, sync and clamped coordinate.

Test Plan:
- Defaults, i_en=1, stb every clk from reset release:
  - o_hs is asserted (low) at h 656..751, i.e. 96 clks per line.
  - o_vs is low for lines 490..491.
  - o_frame_end fires first on clk 419999 and then every 420000 clks.
  - o_active is high for 307200 clks per frame.
- Stb every 4th clk: o_frame_end spacing is 1680000 clks; every pulse is exactly 1 clk wide; o_line_end count per frame is 525.
- Drop i_en at h=100, v=50 for 37 clks: o_x and o_y stay at 100 and 50, no pulses occur; the next adv moves h to 101.
- i_irq_line=200: exactly one o_irq per frame, at h=640, v=200. i_irq_line=600: zero o_irq over 2 frames.
- Assert i_rst_n=0 at h=300, v=300 without a clock edge: counts are immediately 0, o_hs=1, o_vs=1, o_active=1. After release, the next o_frame_end arrives 420000 strobes later.
- Override to 800x600 (H: 800/40/128/88, V: 600/1/4/23, both POL=1):
  - o_hs is high for h 840..967.
  - H_TOTAL=1056, V_TOTAL=628.
  - o_animate fires at v=599, h=1055.
